four_ssd: RTL and testbench
===========================

# four_ssd

Four-digit seven-segment display multiplexer. It takes a 16-bit value as four hex nibbles plus four decimal-point flags. It time-multiplexes them onto one shared 8-bit segment bus with one-hot digit selection. It sits between system logic and a common-anode 4-digit display on a 100 MHz board clock. All display-side outputs are active-low.

## Interface
Parameters:
- DIV_COUNT, default 100000: clock cycles each digit stays selected (1 ms at 100 MHz, giving a 250 Hz full-frame refresh). Legal range is ≥2.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  reset, asynchronous and active-low.
- SSD_Out  output  8  segment bus, active-low. Bit 7 = DP; bits 6:0 = g,f,e,d,c,b,a.
- SSD_Select  output  4  digit enables, active-low, one-hot-low. Bit 0 = rightmost digit.
- SSD_DP  input  4  decimal-point request per digit, active-high. Bit i controls digit i.
- DataIn  input  16  display value. Digit i shows DataIn[4i+3:4i].
- En  input  1  display enable, active-high.

## Operation
- Refresh counter:
  - Counts 0..DIV_COUNT-1 while En=1.
  - On the DIV_COUNT-1 cycle it wraps to 0, and the 2-bit digit index advances 0→1→2→3→0.
- Output registers:
  - While En=1, each edge registers outputs for the current index:
    - SSD_Select = ~(4'b0001 << index).
    - SSD_Out[6:0] = hex decode of nibble[index].
    - SSD_Out[7] = ~SSD_DP[index].
- Hex decode, active-low, shown as the full SSD_Out byte with DP off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - With DP on, clear bit 7.
- En=0:
  - Counter and index are held at 0.
  - Registered outputs are blanked: SSD_Select=4'b1111, SSD_Out=8'hFF.
- DataIn and SSD_DP are sampled every cycle, not latched per frame. A change is visible on the next edge if it affects the currently selected digit.
- Exactly one SSD_Select bit is low at any time while enabled. No cycle ever has two digits selected.

## Timing
- Reset (Rst_n=0, asynchronous): SSD_Out=8'hFF, SSD_Select=4'b1111, counter=0, index=0. Release is synchronous to the next Clk edge.
- Latency: one cycle from index/input to outputs.
- Enable:
  - The first rising edge sampling En=1 drives digit 0.
  - Digit 0 is held for DIV_COUNT cycles, then digit 1, and so on.
  - A full frame is 4×DIV_COUNT cycles.
- En falling mid-frame: the next edge blanks the outputs and zeroes the index. Re-enable always restarts at digit 0.
- Reset asserted mid-operation overrides everything immediately.

## Structure
- Shared package `ssd_pkg`:
  - segment constant array for 0–F (active-low, 7 bits)
  - SEG_BLANK = 7'h7F
  - DIV_COUNT default
- Sub-module `ssd_hex_decoder`: purely combinational, 4-bit nibble in, 7-bit active-low segments out.
- Top level holds the counter, the index, the output registers, and the DP/select logic.

## Test plan
- Reset: hold Rst_n=0 with En=1 and DataIn=16'hABCD → SSD_Out=8'hFF, SSD_Select=4'b1111 throughout. Also assert Rst_n mid-frame → outputs blank within the same cycle.
- Disabled: En=0, DataIn=16'hABCD, SSD_DP=4'b0101 for 20 ns → outputs stay blank (FF / 1111).
- Scan sequence: DIV_COUNT=4, En=1, DataIn=16'hABCD, SSD_DP=4'b0101 → (Select, Out) cycles through:
  - (1110, 21), then (1101, C6), then (1011, 03), then (0111, 88)
  - each held 4 cycles, then repeating
- Decode sweep: step DataIn through 16'h0000..16'hFFFF in 16'h1111 increments with SSD_DP=0 → digit 0 shows the table value for each nibble 0–F.
- Enable toggle: drop En during digit 2 → next edge blanks. Re-raise En → digit 0 appears first and holds a full DIV_COUNT cycles.
- Live update: change DataIn[3:0] from D to 5 while digit 0 is selected → SSD_Out changes from 21 to 12 on the next edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the four-digit seven-segment display multiplexer.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package ssd_pkg;

   localparam int DIV_COUNT_DEFAULT = 100000;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Bus byte: DP lives in bit 7 and is active-low like the segments.
   function automatic logic [7:0] ssd_byte(input logic dp_on, input logic [6:0] seg);
      return {~dp_on, seg};
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup covers all sixteen codes.
   always_comb begin
      seg = SEG_BLANK;
      seg = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/four_ssd.sv
// Four-digit seven-segment multiplexer: one digit selected at a time,
// each held DIV_COUNT cycles, all display outputs registered and active-low.
module four_ssd
   import ssd_pkg::*;
#(
   parameter int DIV_COUNT = DIV_COUNT_DEFAULT
)(
   input  logic        Clk,
   input  logic        Rst_n,
   output logic [7:0]  SSD_Out,
   output logic [3:0]  SSD_Select,
   input  logic [3:0]  SSD_DP,
   input  logic [15:0] DataIn,
   input  logic        En
);

   localparam int CNT_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       idx_r;
   logic [3:0]       nibble_s;
   logic             dp_s;
   logic [6:0]       seg_s;

   // Select the nibble and DP request of the digit currently being driven.
   always_comb begin
      nibble_s = 4'h0;
      dp_s     = 1'b0;
      case (idx_r)
         2'd0:    begin nibble_s = DataIn[3:0];   dp_s = SSD_DP[0]; end
         2'd1:    begin nibble_s = DataIn[7:4];   dp_s = SSD_DP[1]; end
         2'd2:    begin nibble_s = DataIn[11:8];  dp_s = SSD_DP[2]; end
         2'd3:    begin nibble_s = DataIn[15:12]; dp_s = SSD_DP[3]; end
         default: begin nibble_s = 4'h0;          dp_s = 1'b0;      end
      endcase
   end

   ssd_hex_decoder u_dec (
      .nibble (nibble_s),
      .seg    (seg_s)
   );

   // Refresh counter, digit index and registered display outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_r      <= '0;
         idx_r      <= 2'd0;
         SSD_Out    <= 8'hFF;
         SSD_Select <= 4'b1111;
      end else if (!En) begin
         cnt_r      <= '0;
         idx_r      <= 2'd0;
         SSD_Out    <= 8'hFF;
         SSD_Select <= 4'b1111;
      end else begin
         // Outputs reflect the index before it advances, so each digit gets DIV_COUNT edges.
         SSD_Out    <= ssd_byte(dp_s, seg_s);
         SSD_Select <= ~(4'b0001 << idx_r);
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_four_ssd.sv
// Directed self-checking bench for four_ssd with a short refresh period.
module tb_four_ssd;

   localparam int DIV = 4;

   logic        Clk;
   logic        Rst_n;
   logic [7:0]  SSD_Out;
   logic [3:0]  SSD_Select;
   logic [3:0]  SSD_DP;
   logic [15:0] DataIn;
   logic        En;

   int total;
   int bad;

   logic [7:0] hex_tbl [0:15];

   four_ssd #(.DIV_COUNT(DIV)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .SSD_Out    (SSD_Out),
      .SSD_Select (SSD_Select),
      .SSD_DP     (SSD_DP),
      .DataIn     (DataIn),
      .En         (En)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst_n  = 1'b0;
      En     = 1'b1;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0000;
      #2;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (SSD_Out !== 8'hFF || SSD_Select !== 4'b1111) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got out=%h sel=%b want out=ff sel=1111", i, SSD_Out, SSD_Select);
         end
      end
   endtask

   task automatic test_disabled();
      En     = 1'b0;
      Rst_n  = 1'b1;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (SSD_Out !== 8'hFF || SSD_Select !== 4'b1111) begin
            bad++;
            $display("FAIL disabled cyc=%0d got out=%h sel=%b want out=ff sel=1111", i, SSD_Out, SSD_Select);
         end
      end
   endtask

   task automatic test_scan();
      logic [3:0] exp_sel [0:3];
      logic [7:0] exp_out [0:3];
      exp_sel[0] = 4'b1110; exp_out[0] = 8'h21;
      exp_sel[1] = 4'b1101; exp_out[1] = 8'hC6;
      exp_sel[2] = 4'b1011; exp_out[2] = 8'h03;
      exp_sel[3] = 4'b0111; exp_out[3] = 8'h88;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0101;
      En     = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV; c++) begin
               step();
               total++;
               if (SSD_Out !== exp_out[d] || SSD_Select !== exp_sel[d]) begin
                  bad++;
                  $display("FAIL scan f=%0d d=%0d c=%0d got out=%h sel=%b want out=%h sel=%b",
                           f, d, c, SSD_Out, SSD_Select, exp_out[d], exp_sel[d]);
               end
            end
         end
      end
   endtask

   task automatic test_decode_sweep();
      logic [15:0] v;
      SSD_DP = 4'b0000;
      for (int n = 0; n < 16; n++) begin
         v = 16'h1111 * 16'(n);
         En = 1'b0;
         step();
         En     = 1'b1;
         DataIn = v;
         step();
         total++;
         if (SSD_Out !== hex_tbl[n] || SSD_Select !== 4'b1110) begin
            bad++;
            $display("FAIL decode n=%0h got out=%h sel=%b want out=%h sel=1110",
                     n, SSD_Out, SSD_Select, hex_tbl[n]);
         end
      end
   endtask

   task automatic test_enable_toggle();
      En     = 1'b0;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0101;
      step();
      En = 1'b1;
      for (int i = 0; i < 2 * DIV + 1; i++) step();
      total++;
      if (SSD_Select !== 4'b1011 || SSD_Out !== 8'h03) begin
         bad++;
         $display("FAIL toggle_digit2 got out=%h sel=%b want out=03 sel=1011", SSD_Out, SSD_Select);
      end
      En = 1'b0;
      step();
      total++;
      if (SSD_Out !== 8'hFF || SSD_Select !== 4'b1111) begin
         bad++;
         $display("FAIL toggle_blank got out=%h sel=%b want out=ff sel=1111", SSD_Out, SSD_Select);
      end
      En = 1'b1;
      for (int c = 0; c < DIV; c++) begin
         step();
         total++;
         if (SSD_Out !== 8'h21 || SSD_Select !== 4'b1110) begin
            bad++;
            $display("FAIL toggle_restart c=%0d got out=%h sel=%b want out=21 sel=1110", c, SSD_Out, SSD_Select);
         end
      end
      step();
      total++;
      if (SSD_Out !== 8'hC6 || SSD_Select !== 4'b1101) begin
         bad++;
         $display("FAIL toggle_next got out=%h sel=%b want out=c6 sel=1101", SSD_Out, SSD_Select);
      end
   endtask

   task automatic test_live_update();
      En     = 1'b0;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0101;
      step();
      En = 1'b1;
      step();
      total++;
      if (SSD_Out !== 8'h21 || SSD_Select !== 4'b1110) begin
         bad++;
         $display("FAIL live_before got out=%h sel=%b want out=21 sel=1110", SSD_Out, SSD_Select);
      end
      DataIn = 16'hABC5;
      step();
      total++;
      if (SSD_Out !== 8'h12 || SSD_Select !== 4'b1110) begin
         bad++;
         $display("FAIL live_after got out=%h sel=%b want out=12 sel=1110", SSD_Out, SSD_Select);
      end
   endtask

   task automatic test_reset_mid();
      En     = 1'b1;
      DataIn = 16'hABCD;
      SSD_DP = 4'b0101;
      for (int i = 0; i < DIV + 2; i++) step();
      total++;
      if (SSD_Select !== 4'b1101) begin
         bad++;
         $display("FAIL rmid_pre got sel=%b want sel=1101", SSD_Select);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      total++;
      if (SSD_Out !== 8'hFF || SSD_Select !== 4'b1111) begin
         bad++;
         $display("FAIL rmid_async got out=%h sel=%b want out=ff sel=1111", SSD_Out, SSD_Select);
      end
      step();
      Rst_n = 1'b1;
      step();
      total++;
      if (SSD_Out !== 8'h21 || SSD_Select !== 4'b1110) begin
         bad++;
         $display("FAIL rmid_restart got out=%h sel=%b want out=21 sel=1110", SSD_Out, SSD_Select);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      hex_tbl[0]  = 8'hC0; hex_tbl[1]  = 8'hF9; hex_tbl[2]  = 8'hA4; hex_tbl[3]  = 8'hB0;
      hex_tbl[4]  = 8'h99; hex_tbl[5]  = 8'h92; hex_tbl[6]  = 8'h82; hex_tbl[7]  = 8'hF8;
      hex_tbl[8]  = 8'h80; hex_tbl[9]  = 8'h90; hex_tbl[10] = 8'h88; hex_tbl[11] = 8'h83;
      hex_tbl[12] = 8'hC6; hex_tbl[13] = 8'hA1; hex_tbl[14] = 8'h86; hex_tbl[15] = 8'h8E;

      test_reset();
      test_disabled();
      test_scan();
      test_decode_sweep();
      test_enable_toggle();
      test_live_update();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
